alu_iter: RTL

- Multi-cycle integer ALU for the RV32 datapath. It is the consumer of the 4-bit ALUop code that the ALU decoder produces.
- Accepts one operation per handshake (op, A, B) and returns a registered result with a valid/ready handshake.
- Shifts run iteratively, one bit per cycle, using a small shifter instead of a full barrel shifter.
- Sits between the decode/operand-select stage and writeback in the multi-cycle core variant.

---
 rtl/alu_iter_pkg.sv | 27 ++
 rtl/alu_iter_shstep.sv | 28 ++
 rtl/alu_iter.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_iter_pkg.sv
// Shared ALUop encodings and FSM state encodings for alu_iter and its bench.
// Optional build macro ALU_ITER_SHIFT4_EN is consumed by alu_iter.sv.
package alu_iter_pkg;

    // ALUop codes, shared with the ALU decoder
    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSlt   = 4'd5;
    localparam logic [3:0] AluSltu  = 4'd6;
    localparam logic [3:0] AluSll   = 4'd7;
    localparam logic [3:0] AluSrl   = 4'd8;
    localparam logic [3:0] AluSra   = 4'd9;
    localparam logic [3:0] AluCopyB = 4'd10;
    localparam logic [3:0] AluXxx   = 4'd15;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == AluSll) || (op == AluSrl) || (op == AluSra);
    endfunction

endpackage

// File: rtl/alu_iter_shstep.sv
// Combinational step shifter: moves value by 1 or 4 bits left/right per call.
module alu_iter_shstep
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,    // 0: left, 1: right
    input  logic             arith,  // right shifts replicate the MSB
    input  logic             step4,
    output logic [WIDTH-1:0] result
);

    logic fill;
    assign fill = arith & value[WIDTH-1];

    always_comb begin
        result = value;
        unique case ({dir, step4})
            2'b00: result = {value[WIDTH-2:0], 1'b0};
            2'b01: result = {value[WIDTH-5:0], 4'b0000};
            2'b10: result = {fill, value[WIDTH-1:1]};
            2'b11: result = {{4{fill}}, value[WIDTH-1:4]};
            default: result = value;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle integer ALU with iterative shifter and valid/ready handshakes.
// Define ALU_ITER_SHIFT4_EN to let the shifter take 4-bit steps while n >= 4.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             illegal_q, illegal_d;

    logic             step4;
    logic [WIDTH-1:0] sh_out;
    logic             lt_s, lt_u;

`ifdef ALU_ITER_SHIFT4_EN
    assign step4 = (cnt_q >= SW'(4));
`else
    assign step4 = 1'b0;
`endif

    alu_iter_shstep #(
        .WIDTH(WIDTH)
    ) u_shstep (
        .value (result_q),
        .dir   (op_q != AluSll),
        .arith (op_q == AluSra),
        .step4 (step4),
        .result(sh_out)
    );

    assign lt_s = $signed(in_a) < $signed(in_b);
    assign lt_u = in_a < in_b;

    assign in_ready    = (state_q == StIdle) & ~rst;
    assign out_valid   = (state_q == StDone);
    assign out_result  = result_q;
    assign out_illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    op_d      = in_op;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StDone;
                    case (in_op)
                        AluAdd:   result_d = in_a + in_b;
                        AluSub:   result_d = in_a - in_b;
                        AluAnd:   result_d = in_a & in_b;
                        AluOr:    result_d = in_a | in_b;
                        AluXor:   result_d = in_a ^ in_b;
                        AluSlt:   result_d = {{(WIDTH-1){1'b0}}, lt_s};
                        AluSltu:  result_d = {{(WIDTH-1){1'b0}}, lt_u};
                        AluCopyB: result_d = in_b;
                        AluSll, AluSrl, AluSra: begin
                            result_d = in_a;
                            cnt_d    = in_b[SW-1:0];
                            if (in_b[SW-1:0] != '0) state_d = StShift;
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            StShift: begin
                result_d = sh_out;
                cnt_d    = cnt_q - (step4 ? SW'(4) : SW'(1));
                if (cnt_d == '0) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            cnt_q     <= '0;
            op_q      <= AluAdd;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
